// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the five-stage core.
// Merges ID/EX/MEM stall requests into the per-stage stall vector, turns
// exceptions, ERET and MEM-bus timeouts into a flush plus redirect PC,
// suppresses re-triggering for FLUSH_HOLD cycles after each flush, and
// keeps a saturating count of stalled cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal operation; stalls and flushes are generated
// HOLD  | post-flush quiet window; all requests and exceptions ignored
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter logic [15:0] TIMEOUT    = 16'd1024,
   parameter logic [3:0]  FLUSH_HOLD = 4'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        cnt_clr_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        timeout_o,
   output logic        timeout_flag_o,
   output logic [31:0] stall_cnt_o
);

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [31:0] ERET_CODE = 32'h0000_000e;
   localparam logic [15:0] WDT_LAST  = TIMEOUT - 16'd1;

   state_t      r_state;
   logic [3:0]  r_hold_cnt;
   logic [15:0] r_wdt_cnt;

   // Flush/redirect/stall decode; everything is forced quiet while reset is held.
   always_comb begin
      stall     = 6'b000000;
      flush     = 1'b0;
      new_pc    = 32'h0000_0000;
      timeout_o = 1'b0;
      if (!rst && r_state == RUN) begin
         if (excepttype_i != 32'h0000_0000) begin
            flush  = 1'b1;
            new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
         end else if (TIMEOUT != 16'd0 && stallreq_from_mem && r_wdt_cnt == WDT_LAST) begin
            flush     = 1'b1;
            timeout_o = 1'b1;
            new_pc    = EXC_VECTOR;
         end else if (stallreq_from_mem) begin
            stall = 6'b011111;
         end else if (stallreq_from_ex) begin
            stall = 6'b001111;
         end else if (stallreq_from_id) begin
            stall = 6'b000111;
         end
      end
   end

   // RUN/HOLD sequencing with the post-flush hold down-counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_hold_cnt <= 4'd0;
      end else begin
         case (r_state)
            RUN: begin
               if (flush && FLUSH_HOLD != 4'd0) begin
                  r_state    <= HOLD;
                  r_hold_cnt <= FLUSH_HOLD - 4'd1;
               end
            end
            HOLD: begin
               if (r_hold_cnt == 4'd0) begin
                  r_state <= RUN;
               end else begin
                  r_hold_cnt <= r_hold_cnt - 4'd1;
               end
            end
            default: begin
               r_state    <= RUN;
               r_hold_cnt <= 4'd0;
            end
         endcase
      end
   end

   // MEM-stall watchdog; saturates rather than wrapping when disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdt_cnt <= 16'd0;
      end else if (r_state == HOLD || flush || !stallreq_from_mem) begin
         r_wdt_cnt <= 16'd0;
      end else if (r_wdt_cnt != 16'hFFFF) begin
         r_wdt_cnt <= r_wdt_cnt + 16'd1;
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_flag_o <= 1'b0;
      end else if (timeout_o) begin
         timeout_flag_o <= 1'b1;
      end
   end

   // Saturating stall-cycle counter; clear wins over increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= 32'h0000_0000;
      end else if (cnt_clr_i) begin
         stall_cnt_o <= 32'h0000_0000;
      end else if (stall[0] && stall_cnt_o != 32'hFFFF_FFFF) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end

endmodule
